ex_wb_stage: RTL and testbench

- Execute stage plus EX/WB pipeline register: the consumer end of the ID/EX register.
- Takes the latched decode bundle (num1, ImmData_out, inst_code, j_adr, PCsrc, RegWrite, Sel1), computes the 8-bit result and registers it for register-file writeback.
- Drives the forwarding bus back to decode and the PC redirect/flush back to fetch.
- A small flush FSM squashes wrong-path instructions after a taken jump.

---
 rtl/ex_wb_stage_pkg.sv | 31 +++
 rtl/ex_wb_stage_if.sv | 40 ++++
 rtl/ex_wb_stage_alu.sv | 17 +
 rtl/ex_wb_stage.sv | 100 ++++++++++
 tb/tb_ex_wb_stage.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ex_wb_stage_pkg.sv
// rtl/ex_wb_stage_pkg.sv - shared constants, field slices and FSM state type for the EX/WB stage
package ex_wb_stage_pkg;

   localparam int EX_DATA_W       = 8;
   localparam int EX_JADR_W       = 6;
   localparam int EX_FLUSH_CYCLES = 2;

   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_JMP = 2'b11;

   // inst_code layout: [7:6] op, [5:3] rd, [2:0] rs
   localparam int OP_HI = 7;
   localparam int OP_LO = 6;
   localparam int RD_HI = 5;
   localparam int RD_LO = 3;
   localparam int RS_HI = 2;
   localparam int RS_LO = 0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH1 = 2'd1,
      ST_FLUSH2 = 2'd2,
      ST_FLUSH3 = 2'd3
   } ex_state_t;

   function automatic logic [2:0] rd_field(input logic [7:0] inst);
      return inst[RD_HI:RD_LO];
   endfunction

endpackage

// File: rtl/ex_wb_stage_if.sv
// rtl/ex_wb_stage_if.sv - ID/EX bundle in, writeback/forwarding/redirect out
interface ex_wb_stage_if
   import ex_wb_stage_pkg::*;
#(
   parameter int DATA_W = EX_DATA_W,
   parameter int JADR_W = EX_JADR_W
);

   logic [DATA_W-1:0] num1;
   logic [DATA_W-1:0] ImmData_ex;
   logic [7:0]        inst_code_ex;
   logic [JADR_W-1:0] j_adr_ex;
   logic              PCsrc_ex;
   logic              RegWrite_ex;
   logic              Sel1_ex;

   logic              wb_en;
   logic [2:0]        wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              fwd_valid;
   logic [2:0]        fwd_rd;
   logic [DATA_W-1:0] fwd_data;
   logic              pc_redirect;
   logic [DATA_W-1:0] pc_target;
   logic              flush;
   logic [7:0]        wb_count;

   modport master (
      output num1, ImmData_ex, inst_code_ex, j_adr_ex, PCsrc_ex, RegWrite_ex, Sel1_ex,
      input  wb_en, wb_addr, wb_data, fwd_valid, fwd_rd, fwd_data,
      input  pc_redirect, pc_target, flush, wb_count
   );

   modport slave (
      input  num1, ImmData_ex, inst_code_ex, j_adr_ex, PCsrc_ex, RegWrite_ex, Sel1_ex,
      output wb_en, wb_addr, wb_data, fwd_valid, fwd_rd, fwd_data,
      output pc_redirect, pc_target, flush, wb_count
   );

endinterface

// File: rtl/ex_wb_stage_alu.sv
// rtl/ex_wb_stage_alu.sv - combinational operand select and wrapping adder
module ex_alu #(
   parameter int DATA_W = 8
) (
   input  logic              sel1,
   input  logic [DATA_W-1:0] num1,
   input  logic [DATA_W-1:0] imm_data,
   output logic [DATA_W-1:0] res
);

   logic [DATA_W-1:0] sum;

   // carry out is deliberately dropped: the result wraps mod 2^DATA_W
   assign sum = num1 + imm_data;
   assign res = sel1 ? sum : imm_data;

endmodule

// File: rtl/ex_wb_stage.sv
// rtl/ex_wb_stage.sv - execute stage with EX/WB register, forwarding bus and jump flush FSM
module ex_wb_stage
   import ex_wb_stage_pkg::*;
#(
   parameter int DATA_W       = EX_DATA_W,
   parameter int JADR_W       = EX_JADR_W,
   parameter int FLUSH_CYCLES = EX_FLUSH_CYCLES
) (
   input  logic         clk,
   input  logic         reset,
   ex_wb_stage_if.slave bus
);

   ex_state_t         state;
   ex_state_t         state_next;
   logic              live;
   logic [DATA_W-1:0] res;

   logic              wb_en;
   logic [2:0]        wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [7:0]        wb_count;
   logic              pc_redirect;
   logic [DATA_W-1:0] pc_target;

   logic              wb_en_next;
   logic              redirect_next;
   logic [DATA_W-1:0] target_next;

   logic              unused_inst_bits;
   assign unused_inst_bits = ^{bus.inst_code_ex[OP_HI:OP_LO], bus.inst_code_ex[RS_HI:RS_LO]};

   ex_alu #(.DATA_W(DATA_W)) u_alu (
      .sel1     (bus.Sel1_ex),
      .num1     (bus.num1),
      .imm_data (bus.ImmData_ex),
      .res      (res)
   );

   // only RUN executes; every FLUSHk slot treats the bundle as a bubble
   assign live = (state == ST_RUN);

   always_comb begin
      state_next    = state;
      redirect_next = 1'b0;
      target_next   = pc_target;
      wb_en_next    = 1'b0;
      case (state)
         ST_RUN: begin
            wb_en_next = bus.RegWrite_ex & bus.PCsrc_ex;
            if (!bus.PCsrc_ex) begin
               state_next    = ST_FLUSH1;
               redirect_next = 1'b1;
               target_next   = {{(DATA_W-JADR_W){1'b0}}, bus.j_adr_ex};
            end
         end
         ST_FLUSH1: state_next = (FLUSH_CYCLES > 1) ? ST_FLUSH2 : ST_RUN;
         ST_FLUSH2: state_next = (FLUSH_CYCLES > 2) ? ST_FLUSH3 : ST_RUN;
         ST_FLUSH3: state_next = ST_RUN;
         default:   state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         pc_redirect <= 1'b0;
         pc_target   <= '0;
         wb_en       <= 1'b0;
         wb_addr     <= '0;
         wb_data     <= '0;
         wb_count    <= '0;
      end else begin
         state       <= state_next;
         pc_redirect <= redirect_next;
         pc_target   <= target_next;
         wb_en       <= wb_en_next;
         if (live) begin
            wb_addr <= rd_field(bus.inst_code_ex);
            wb_data <= res;
         end
         if (wb_en_next) begin
            wb_count <= wb_count + 8'd1;
         end
      end
   end

   // forwarding taps the registered writeback, never the raw inputs
   assign bus.wb_en       = wb_en;
   assign bus.wb_addr     = wb_addr;
   assign bus.wb_data     = wb_data;
   assign bus.fwd_valid   = wb_en;
   assign bus.fwd_rd      = wb_addr;
   assign bus.fwd_data    = wb_data;
   assign bus.pc_redirect = pc_redirect;
   assign bus.pc_target   = pc_target;
   assign bus.flush       = (state != ST_RUN);
   assign bus.wb_count    = wb_count;

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb/tb_ex_wb_stage.sv - randomized and directed checks of ex_wb_stage against a behavioural model
module tb_ex_wb_stage;

   localparam int NFLUSH = 2;

   logic clk;
   logic reset;

   int tests_run;
   int tests_failed;

   // reference model state
   int        m_flush_left;
   bit        m_wb_en;
   bit [2:0]  m_wb_addr;
   bit [7:0]  m_wb_data;
   bit        m_redirect;
   bit [7:0]  m_target;
   int        m_count;

   ex_wb_stage_if #(.DATA_W(8), .JADR_W(6)) bus ();

   ex_wb_stage #(.DATA_W(8), .JADR_W(6), .FLUSH_CYCLES(NFLUSH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_flush_left = 0;
      m_wb_en      = 0;
      m_wb_addr    = 0;
      m_wb_data    = 0;
      m_redirect   = 0;
      m_target     = 0;
      m_count      = 0;
   endtask

   task automatic check_all(input string ctx);
      check_eq({ctx, ".wb_en"},       bus.wb_en,       m_wb_en);
      check_eq({ctx, ".wb_addr"},     bus.wb_addr,     m_wb_addr);
      check_eq({ctx, ".wb_data"},     bus.wb_data,     m_wb_data);
      check_eq({ctx, ".fwd_valid"},   bus.fwd_valid,   m_wb_en);
      check_eq({ctx, ".fwd_rd"},      bus.fwd_rd,      m_wb_addr);
      check_eq({ctx, ".fwd_data"},    bus.fwd_data,    m_wb_data);
      check_eq({ctx, ".pc_redirect"}, bus.pc_redirect, m_redirect);
      check_eq({ctx, ".pc_target"},   bus.pc_target,   m_target);
      check_eq({ctx, ".flush"},       bus.flush,       (m_flush_left > 0));
      check_eq({ctx, ".wb_count"},    bus.wb_count,    m_count[7:0]);
   endtask

   // one instruction per clock: drive, clock, advance model, compare
   task automatic step(input string ctx, input bit sel1, input bit [7:0] n1, input bit [7:0] imm,
                       input bit [2:0] rd, input bit rw, input bit pcsrc, input bit [5:0] jadr);
      bus.num1         = n1;
      bus.ImmData_ex   = imm;
      bus.inst_code_ex = {pcsrc ? 2'b00 : 2'b11, rd, 3'($urandom_range(0, 7))};
      bus.j_adr_ex     = jadr;
      bus.PCsrc_ex     = pcsrc;
      bus.RegWrite_ex  = rw;
      bus.Sel1_ex      = sel1;
      @(posedge clk);
      if (m_flush_left == 0) begin
         m_wb_en   = rw && pcsrc;
         m_wb_addr = rd;
         m_wb_data = sel1 ? 8'((int'(n1) + int'(imm)) % 256) : imm;
         if (m_wb_en) m_count = (m_count + 1) % 256;
         m_redirect = !pcsrc;
         if (!pcsrc) begin
            m_target     = {2'b00, jadr};
            m_flush_left = NFLUSH;
         end
      end else begin
         m_wb_en    = 0;
         m_redirect = 0;
         m_flush_left--;
      end
      #1;
      check_all(ctx);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      model_reset();
      bus.num1 = 0; bus.ImmData_ex = 0; bus.inst_code_ex = 0; bus.j_adr_ex = 0;
      bus.PCsrc_ex = 1; bus.RegWrite_ex = 0; bus.Sel1_ex = 0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;

      step("mov", 0, 8'h00, 8'h5A, 3'd3, 1, 1, 6'h00);
      check_eq("mov.data_const", bus.wb_data, 8'h5A);
      check_eq("mov.count_const", bus.wb_count, 8'd1);

      step("add_ovf", 1, 8'hF0, 8'h20, 3'd1, 1, 1, 6'h00);
      check_eq("add_ovf.data_const", bus.wb_data, 8'h10);

      step("jmp", 0, 8'h00, 8'h77, 3'd5, 1, 0, 6'h2A);
      check_eq("jmp.target_const", bus.pc_target, 8'h2A);
      check_eq("jmp.wb_en_const", bus.wb_en, 1'b0);
      step("sq1", 0, 8'h00, 8'h11, 3'd2, 1, 1, 6'h00);
      step("sq2", 0, 8'h00, 8'h22, 3'd4, 1, 1, 6'h00);
      check_eq("sq2.count_const", bus.wb_count, 8'd2);
      step("after", 0, 8'h00, 8'h33, 3'd6, 1, 1, 6'h00);
      check_eq("after.wb_en_const", bus.wb_en, 1'b1);

      step("jj1", 0, 8'h00, 8'h00, 3'd0, 0, 0, 6'h2A);
      step("jj2", 0, 8'h00, 8'h00, 3'd0, 0, 0, 6'h11);
      check_eq("jj2.redirect_const", bus.pc_redirect, 1'b0);
      check_eq("jj2.target_const", bus.pc_target, 8'h2A);
      step("jj3", 0, 8'h00, 8'h00, 3'd0, 0, 1, 6'h00);

      // asynchronous reset while sitting in FLUSH1
      step("rj", 0, 8'h00, 8'h00, 3'd0, 1, 0, 6'h15);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #2 reset = 1'b1;
      step("post_rst", 0, 8'h00, 8'hC3, 3'd7, 1, 1, 6'h00);
      check_eq("post_rst.wb_en_const", bus.wb_en, 1'b1);

      for (int i = 0; i < 256; i++) begin
         step("wrap", 1, 8'(i), 8'h01, 3'(i), 1, 1, 6'h00);
         if (i == 253) check_eq("wrap.ff", bus.wb_count, 8'hFF);
         if (i == 254) check_eq("wrap.00", bus.wb_count, 8'h00);
      end

      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0), 6'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
